// File: rtl/spi_ram_arbiter.sv
// Shares a single-port synchronous RAM between a decoded SPI command stream (one pending access) and a host port, round-robin.
// Optional feature macro ADDR_AUTOINC_EN: SPI wr/rd address auto-increment after each SPI access.
`timescale 1ns/1ps
module spi_ram_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW+1:0] rx_data,
  input  logic          rx_valid,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  output logic          spi_overrun,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [DW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic [DW-1:0] h_rdata,
  output logic          h_rvalid,
  output logic [DW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam logic [1:0] CMD_LDWR = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_LDRD = 2'b10;
  localparam logic [1:0] CMD_RD   = 2'b11;

  state_t        state_q, state_d;
  logic [DW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] rd_addr_q, rd_addr_d;
  logic          pend_q, pend_d;
  logic          pend_we_q, pend_we_d;
  logic [DW-1:0] pend_addr_q, pend_addr_d;
  logic [DW-1:0] pend_wdata_q, pend_wdata_d;
  logic          cur_spi_q, cur_spi_d;
  logic          cur_we_q, cur_we_d;
  logic [DW-1:0] cur_addr_q, cur_addr_d;
  logic [DW-1:0] cur_wdata_q, cur_wdata_d;
  logic          last_spi_q, last_spi_d;
  logic          overrun_q, overrun_d;
  logic          tx_valid_q, tx_valid_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          h_rvalid_q, h_rvalid_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;

  logic [1:0]    cmd;
  logic [DW-1:0] payload;
  logic          spi_issue;
  logic          spi_win;

  assign cmd     = rx_data[DW+1:DW];
  assign payload = rx_data[DW-1:0];
  // On a tie the side that did not win last time goes; last_spi_q=0 after reset favours SPI.
  assign spi_win = pend_q && (!h_req || !last_spi_q);

  always_comb begin
    state_d     = state_q;
    cur_spi_d   = cur_spi_q;
    cur_we_d    = cur_we_q;
    cur_addr_d  = cur_addr_q;
    cur_wdata_d = cur_wdata_q;
    last_spi_d  = last_spi_q;
    tx_valid_d  = 1'b0;
    tx_data_d   = tx_data_q;
    h_rvalid_d  = 1'b0;
    h_rdata_d   = h_rdata_q;
    spi_issue   = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    h_gnt       = 1'b0;

    case (state_q)
      IDLE: begin
        if (spi_win) begin
          cur_spi_d   = 1'b1;
          cur_we_d    = pend_we_q;
          cur_addr_d  = pend_addr_q;
          cur_wdata_d = pend_wdata_q;
          last_spi_d  = 1'b1;
          state_d     = ACCESS;
        end else if (h_req) begin
          cur_spi_d   = 1'b0;
          cur_we_d    = h_we;
          cur_addr_d  = h_addr;
          cur_wdata_d = h_wdata;
          last_spi_d  = 1'b0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        ram_addr  = cur_addr_q;
        ram_wdata = cur_wdata_q;
        ram_we    = cur_we_q;
        ram_re    = !cur_we_q;
        h_gnt     = !cur_spi_q;
        spi_issue = cur_spi_q;
        state_d   = cur_we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        if (cur_spi_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ram_rdata;
        end else begin
          h_rvalid_d = 1'b1;
          h_rdata_d  = ram_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // pend_q stays set through the ACCESS cycle, so a new 01/11 there is dropped too.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    pend_d       = pend_q && !spi_issue;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    overrun_d    = overrun_q;

`ifdef ADDR_AUTOINC_EN
    if (spi_issue) begin
      if (cur_we_q) begin
        wr_addr_d = wr_addr_q + {{(DW-1){1'b0}}, 1'b1};
      end else begin
        rd_addr_d = rd_addr_q + {{(DW-1){1'b0}}, 1'b1};
      end
    end
`endif

    if (rx_valid) begin
      case (cmd)
        CMD_LDWR: wr_addr_d = payload;
        CMD_LDRD: rd_addr_d = payload;
        CMD_WR: begin
          if (pend_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_d       = 1'b1;
            pend_we_d    = 1'b1;
            pend_addr_d  = wr_addr_q;
            pend_wdata_d = payload;
          end
        end
        CMD_RD: begin
          if (pend_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_d       = 1'b1;
            pend_we_d    = 1'b0;
            pend_addr_d  = rd_addr_q;
            pend_wdata_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      cur_spi_q    <= 1'b0;
      cur_we_q     <= 1'b0;
      cur_addr_q   <= '0;
      cur_wdata_q  <= '0;
      last_spi_q   <= 1'b0;
      overrun_q    <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      h_rvalid_q   <= 1'b0;
      h_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      cur_spi_q    <= cur_spi_d;
      cur_we_q     <= cur_we_d;
      cur_addr_q   <= cur_addr_d;
      cur_wdata_q  <= cur_wdata_d;
      last_spi_q   <= last_spi_d;
      overrun_q    <= overrun_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      h_rvalid_q   <= h_rvalid_d;
      h_rdata_q    <= h_rdata_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign h_rvalid    = h_rvalid_q;
  assign h_rdata     = h_rdata_q;
  assign spi_overrun = overrun_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: RAM model, event log sampled 2ns after each rising edge.
`timescale 1ns/1ps
module tb_spi_ram_arbiter;

`ifdef ADDR_AUTOINC_EN
  localparam logic [7:0] AI = 8'd1;
`else
  localparam logic [7:0] AI = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       spi_overrun;
  logic       h_req = 1'b0;
  logic       h_we = 1'b0;
  logic [7:0] h_addr = '0;
  logic [7:0] h_wdata = '0;
  logic       h_gnt;
  logic [7:0] h_rdata;
  logic       h_rvalid;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       ram_re;
  logic [7:0] ram_rdata;

  int vec = 0;
  int bad = 0;
  int cyc = 0;

  spi_ram_arbiter #(.DW(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .spi_overrun(spi_overrun),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  logic [7:0] wa_log[$];
  logic [7:0] wd_log[$];
  int         wc_log[$];
  logic       ws_log[$];
  int         tx_n = 0, tx_cyc = 0, gnt_n = 0, gnt_cyc = 0, rv_n = 0, rv_cyc = 0;
  logic [7:0] tx_last = '0, rv_last = '0;

  always begin
    @(posedge clk);
    #2;
    if (ram_we) begin
      wa_log.push_back(ram_addr);
      wd_log.push_back(ram_wdata);
      wc_log.push_back(cyc);
      ws_log.push_back(!h_gnt);
    end
    if (tx_valid) begin tx_n++; tx_cyc = cyc; tx_last = tx_data; end
    if (h_gnt) begin gnt_n++; gnt_cyc = cyc; end
    if (h_rvalid) begin rv_n++; rv_cyc = cyc; rv_last = h_rdata; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [9:0] v, input int gap);
    rx_data = v;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data = '0;
    tick(gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    vec++; if ({tx_valid, h_rvalid, h_gnt, spi_overrun} !== 4'b0) begin bad++;
      $display("FAIL reset_strobes: got %b expected 0000", {tx_valid, h_rvalid, h_gnt, spi_overrun}); end
    vec++; if ({tx_data, h_rdata} !== 16'h0) begin bad++;
      $display("FAIL reset_data: got %h expected 0000", {tx_data, h_rdata}); end
    vec++; if ({ram_we, ram_re, ram_addr, ram_wdata} !== 18'h0) begin bad++;
      $display("FAIL reset_ram: got %h expected 0", {ram_we, ram_re, ram_addr, ram_wdata}); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_spi_write_read();
    int n0, t0, c1, c3;
    n0 = wa_log.size();
    t0 = tx_n;
    send_rx(10'h005, 4);
    c1 = cyc;
    send_rx(10'h1A5, 4);
    send_rx(10'h205, 4);
    c3 = cyc;
    send_rx(10'h300, 8);
    vec++; if (wa_log.size() !== n0 + 1) begin bad++;
      $display("FAIL spi_wr_count: got %0d expected %0d", wa_log.size() - n0, 1); end
    vec++; if (wa_log[n0] !== 8'h05 || wd_log[n0] !== 8'hA5) begin bad++;
      $display("FAIL spi_wr_addr_data: got %h/%h expected 05/a5", wa_log[n0], wd_log[n0]); end
    vec++; if (wc_log[n0] !== c1 + 2) begin bad++;
      $display("FAIL spi_wr_latency: got cyc %0d expected %0d", wc_log[n0], c1 + 2); end
    vec++; if (tx_n - t0 !== 1 || tx_last !== 8'hA5) begin bad++;
      $display("FAIL spi_rd_tx: got n=%0d data=%h expected n=1 data=a5", tx_n - t0, tx_last); end
    vec++; if (tx_cyc !== c3 + 4) begin bad++;
      $display("FAIL spi_rd_latency: got cyc %0d expected %0d", tx_cyc, c3 + 4); end
    vec++; if (tx_valid !== 1'b0 || tx_data !== 8'hA5) begin bad++;
      $display("FAIL tx_data_hold: got v=%b d=%h expected v=0 d=a5", tx_valid, tx_data); end
  endtask

  task automatic test_arbitration();
    int n0, g0, c;
    do_reset();
    n0 = wa_log.size();
    g0 = gnt_n;
    c = cyc;
    // Host raises h_req as the SPI entry becomes pending so both meet in IDLE.
    rx_data = 10'h155; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0; rx_data = '0;
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h10; h_wdata = 8'h3C;
    for (int i = 0; i < 12 && gnt_n == g0; i++) tick(1);
    h_req = 1'b0;
    tick(3);
    vec++; if (wa_log.size() !== n0 + 2) begin bad++;
      $display("FAIL tie1_count: got %0d expected 2", wa_log.size() - n0); end
    vec++; if (ws_log[n0] !== 1'b1 || wa_log[n0] !== 8'h00 || wd_log[n0] !== 8'h55 || wc_log[n0] !== c + 2) begin bad++;
      $display("FAIL tie1_spi_first: got spi=%b %h/%h cyc %0d expected spi=1 00/55 cyc %0d",
               ws_log[n0], wa_log[n0], wd_log[n0], wc_log[n0], c + 2); end
    vec++; if (ws_log[n0+1] !== 1'b0 || wa_log[n0+1] !== 8'h10 || wd_log[n0+1] !== 8'h3C || gnt_cyc !== c + 4) begin bad++;
      $display("FAIL tie1_host_next: got spi=%b %h/%h gnt cyc %0d expected spi=0 10/3c cyc %0d",
               ws_log[n0+1], wa_log[n0+1], wd_log[n0+1], gnt_cyc, c + 4); end

    send_rx(10'h030, 2);
    send_rx(10'h1EE, 5);
    n0 = wa_log.size();
    g0 = gnt_n;
    c = cyc;
    rx_data = 10'h177; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0; rx_data = '0;
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h11; h_wdata = 8'h5A;
    for (int i = 0; i < 12 && gnt_n == g0; i++) tick(1);
    h_req = 1'b0;
    tick(4);
    vec++; if (ws_log[n0] !== 1'b0 || wa_log[n0] !== 8'h11 || wd_log[n0] !== 8'h5A || gnt_cyc !== c + 2) begin bad++;
      $display("FAIL tie2_host_first: got spi=%b %h/%h gnt cyc %0d expected spi=0 11/5a cyc %0d",
               ws_log[n0], wa_log[n0], wd_log[n0], gnt_cyc, c + 2); end
    vec++; if (ws_log[n0+1] !== 1'b1 || wa_log[n0+1] !== 8'h30 + AI || wd_log[n0+1] !== 8'h77 || wc_log[n0+1] !== c + 4) begin bad++;
      $display("FAIL tie2_spi_next: got spi=%b %h/%h cyc %0d expected spi=1 %h/77 cyc %0d",
               ws_log[n0+1], wa_log[n0+1], wd_log[n0+1], wc_log[n0+1], 8'h30 + AI, c + 4); end
  endtask

  task automatic test_host_read();
    int m, g0, r0;
    g0 = gnt_n;
    r0 = rv_n;
    m = cyc;
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10;
    for (int i = 0; i < 12 && gnt_n == g0; i++) tick(1);
    h_req = 1'b0;
    tick(4);
    vec++; if (gnt_n - g0 !== 1 || gnt_cyc !== m + 1) begin bad++;
      $display("FAIL host_gnt: got n=%0d cyc %0d expected n=1 cyc %0d", gnt_n - g0, gnt_cyc, m + 1); end
    vec++; if (rv_n - r0 !== 1 || rv_cyc !== m + 3 || rv_last !== 8'h3C) begin bad++;
      $display("FAIL host_rvalid: got n=%0d cyc %0d data %h expected n=1 cyc %0d data 3c",
               rv_n - r0, rv_cyc, rv_last, m + 3); end
    vec++; if (h_rvalid !== 1'b0 || h_rdata !== 8'h3C) begin bad++;
      $display("FAIL h_rdata_hold: got v=%b d=%h expected v=0 d=3c", h_rvalid, h_rdata); end
  endtask

  task automatic test_overrun();
    int n0, m;
    send_rx(10'h020, 3);
    n0 = wa_log.size();
    m = cyc;
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10;
    tick(1);
    h_req = 1'b0;
    rx_data = 10'h101; rx_valid = 1'b1;
    tick(1);
    rx_data = 10'h102;
    tick(1);
    rx_valid = 1'b0; rx_data = '0;
    tick(6);
    vec++; if (wa_log.size() !== n0 + 1 || wa_log[n0] !== 8'h20 || wd_log[n0] !== 8'h01 || wc_log[n0] !== m + 4) begin bad++;
      $display("FAIL ovr_first_written: got n=%0d %h/%h cyc %0d expected n=1 20/01 cyc %0d",
               wa_log.size() - n0, wa_log[n0], wd_log[n0], wc_log[n0], m + 4); end
    vec++; if (spi_overrun !== 1'b1) begin bad++;
      $display("FAIL ovr_flag: got %b expected 1", spi_overrun); end
    send_rx(10'h121, 6);
    vec++; if (wa_log[n0+1] !== 8'h20 + AI || wd_log[n0+1] !== 8'h21) begin bad++;
      $display("FAIL ovr_later_write: got %h/%h expected %h/21", wa_log[n0+1], wd_log[n0+1], 8'h20 + AI); end
    vec++; if (spi_overrun !== 1'b1) begin bad++;
      $display("FAIL ovr_sticky: got %b expected 1", spi_overrun); end
  endtask

  task automatic test_autoinc();
    int n0;
    logic [7:0] exp_a;
    do_reset();
    vec++; if (spi_overrun !== 1'b0) begin bad++;
      $display("FAIL ovr_reset_clear: got %b expected 0", spi_overrun); end
    n0 = wa_log.size();
    send_rx(10'h0FF, 3);
    send_rx(10'h111, 6);
    send_rx(10'h122, 6);
    exp_a = 8'hFF + AI;
    vec++; if (wa_log.size() !== n0 + 2 || wa_log[n0] !== 8'hFF || wd_log[n0] !== 8'h11) begin bad++;
      $display("FAIL autoinc_first: got n=%0d %h/%h expected n=2 ff/11", wa_log.size() - n0, wa_log[n0], wd_log[n0]); end
    vec++; if (wa_log[n0+1] !== exp_a || wd_log[n0+1] !== 8'h22) begin bad++;
      $display("FAIL autoinc_wrap: got %h/%h expected %h/22", wa_log[n0+1], wd_log[n0+1], exp_a); end
  endtask

  task automatic test_reset_mid_read();
    int t0, c;
    send_rx(10'h205, 3);
    t0 = tx_n;
    c = cyc;
    send_rx(10'h300, 0);
    tick(1);
    vec++; if (ram_re !== 1'b1 || ram_addr !== 8'h05) begin bad++;
      $display("FAIL midrst_access: got re=%b addr=%h expected re=1 addr=05", ram_re, ram_addr); end
    tick(1);
    rst = 1'b1;
    tick(1);
    vec++; if ({tx_valid, h_rvalid, h_gnt, spi_overrun, ram_we, ram_re} !== 6'b0 || {tx_data, h_rdata, ram_addr, ram_wdata} !== 32'h0) begin bad++;
      $display("FAIL midrst_outputs: got %b %h expected all zero",
               {tx_valid, h_rvalid, h_gnt, spi_overrun, ram_we, ram_re}, {tx_data, h_rdata, ram_addr, ram_wdata}); end
    rst = 1'b0;
    tick(6);
    vec++; if (tx_n - t0 !== 0) begin bad++;
      $display("FAIL midrst_no_strobe: got %0d tx strobes expected 0 (from cyc %0d)", tx_n - t0, c); end
    send_rx(10'h205, 3);
    t0 = tx_n;
    c = cyc;
    send_rx(10'h300, 7);
    vec++; if (tx_n - t0 !== 1 || tx_last !== 8'hA5 || tx_cyc !== c + 4) begin bad++;
      $display("FAIL midrst_next_read: got n=%0d d=%h cyc %0d expected n=1 d=a5 cyc %0d",
               tx_n - t0, tx_last, tx_cyc, c + 4); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_spi_write_read();
    test_arbitration();
    test_host_read();
    test_overrun();
    test_autoinc();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
